// File: rtl/navegador_pkg.sv
// navegador_pkg
//   Shared definitions for the push-button cursor navigator:
//   - dir_t   : direction encoding; its numeric value also selects the
//               matching bit of the 4-bit direction-button vector
//   - state_t : direction FSM state encoding
//   - default grid size and auto-repeat timing constants
//   - prioridad(): picks one direction out of several simultaneous rises
package navegador_pkg;

  typedef enum logic [1:0] {
    ARRIBA = 2'd0,
    ABAJO  = 2'd1,
    IZQ    = 2'd2,
    DER    = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Index of the select button in the 5-bit button vector; the four
  // direction buttons occupy indices 0..3 in dir_t order.
  localparam int BTN_ELIGE = 4;

  localparam int COLS_DEF       = 32;
  localparam int ROWS_DEF       = 16;
  localparam int HOLD_CYC_DEF   = 50_000_000;
  localparam int REPEAT_CYC_DEF = 10_000_000;

  // Fixed priority arriba > abajo > izq > der when rises coincide.
  function automatic dir_t prioridad(input logic [3:0] rises);
    dir_t d;
    if (rises[0])      d = ARRIBA;
    else if (rises[1]) d = ABAJO;
    else if (rises[2]) d = IZQ;
    else               d = DER;
    return d;
  endfunction

endpackage

// File: rtl/navegador_cursor_if.sv
// navegador_cursor_if
//   Bundles the five filtered button levels with the cursor/select outputs.
//   Modports:
//     master : button source / cursor consumer (drives boton_*, reads cursor)
//     slave  : the navigator itself (reads boton_*, drives cursor/select)
//   Signals:
//     boton_arriba/abajo/izq/der/elige : debounced button levels
//     cursor_col, cursor_row           : current cursor position
//     mov_pulse                        : one cycle after each cursor change
//     sel_pulse, sel_addr              : select strobe with linear address
interface navegador_cursor_if import navegador_pkg::*; #(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) ();

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int ADDR_W = $clog2(COLS * ROWS);

  logic              boton_arriba;
  logic              boton_abajo;
  logic              boton_izq;
  logic              boton_der;
  logic              boton_elige;
  logic [COL_W-1:0]  cursor_col;
  logic [ROW_W-1:0]  cursor_row;
  logic              mov_pulse;
  logic              sel_pulse;
  logic [ADDR_W-1:0] sel_addr;

  modport master (
    output boton_arriba, boton_abajo, boton_izq, boton_der, boton_elige,
    input  cursor_col, cursor_row, mov_pulse, sel_pulse, sel_addr
  );

  modport slave (
    input  boton_arriba, boton_abajo, boton_izq, boton_der, boton_elige,
    output cursor_col, cursor_row, mov_pulse, sel_pulse, sel_addr
  );

endinterface

// File: rtl/navegador_cursor_detector_flanco.sv
// detector_flanco
//   Single-bit rising-edge detector for a filtered button level.
//   Ports:
//     clk   : clock
//     reset : synchronous active-high reset
//     level : button level
//     rise  : high while level=1 and the previous sampled level was 0
//   The previous-value register keeps sampling the input while reset is
//   asserted, so a button already held when reset is released produces
//   no rise.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  // Reset deliberately loads the live input rather than 0.
  always_ff @(posedge clk) begin
    if (reset) prev <= level;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/navegador_cursor.sv
// navegador_cursor
//   Turns five debounced push-button levels into text-cursor motion on a
//   COLS x ROWS grid: single step per press, auto-repeat while a direction
//   stays held, wrap-around at row/column ends, and a one-cycle select
//   strobe carrying row*COLS+col.
//   Ports:
//     clk_100Mhz : system clock, rising edge
//     reset      : synchronous active-high reset
//     bus        : navegador_cursor_if.slave (buttons in, cursor/select out)
module navegador_cursor import navegador_pkg::*; #(
  parameter int COLS       = COLS_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int REPEAT_CYC = REPEAT_CYC_DEF
) (
  input logic               clk_100Mhz,
  input logic               reset,
  navegador_cursor_if.slave bus
);

  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int ADDR_W  = $clog2(COLS * ROWS);
  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(ROWS - 1);

  logic [4:0] levels;
  logic [4:0] rises;
  logic [3:0] dir_rises;
  logic [3:0] dir_levels;

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic held;
  logic move_en;
  dir_t move_dir;

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              mov_q;
  logic              sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] lin_addr;

  // Bit order follows dir_t so a direction indexes its own button.
  assign levels = {bus.boton_elige, bus.boton_der, bus.boton_izq,
                   bus.boton_abajo, bus.boton_arriba};

  for (genvar i = 0; i < 5; i++) begin : g_flanco
    detector_flanco u_flanco (
      .clk   (clk_100Mhz),
      .reset (reset),
      .level (levels[i]),
      .rise  (rises[i])
    );
  end

  assign dir_rises  = rises[3:0];
  assign dir_levels = levels[3:0];
  assign held       = dir_levels[dir_q];

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= ARRIBA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Release always wins over terminal count, so a button let go on the
  // same edge the counter expires produces no move.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|dir_rises) begin
          dir_d   = prioridad(dir_rises);
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!held) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!held) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Other direction rises are not looked at outside IDLE, so they are
  // dropped rather than queued.
  always_comb begin
    move_en  = 1'b0;
    move_dir = dir_q;
    case (state_q)
      IDLE: begin
        move_en  = |dir_rises;
        move_dir = prioridad(dir_rises);
      end
      HOLD:    move_en = held && (cnt_q == HOLD_LAST);
      REPEAT:  move_en = held && (cnt_q == REPEAT_LAST);
      default: move_en = 1'b0;
    endcase
  end

  // Wrap arithmetic: horizontal moves carry into the row at line ends.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    case (move_dir)
      DER: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      IZQ: begin
        if (col_q == '0) begin
          col_d = COL_LAST;
          row_d = (row_q == '0) ? ROW_LAST : row_q - ROW_W'(1);
        end else begin
          col_d = col_q - COL_W'(1);
        end
      end
      ARRIBA: row_d = (row_q == '0) ? ROW_LAST : row_q - ROW_W'(1);
      ABAJO:  row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      default: begin
        col_d = col_q;
        row_d = row_q;
      end
    endcase
  end

  // Uses the registered cursor, i.e. the position before any move taken
  // on the same edge. COLS is constant, so this reduces to a shift for
  // power-of-two widths.
  assign lin_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

  // Cursor, move strobe and select capture.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      mov_q  <= 1'b0;
      sel_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      mov_q <= move_en;
      sel_q <= rises[BTN_ELIGE];
      if (move_en) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      if (rises[BTN_ELIGE]) addr_q <= lin_addr;
    end
  end

  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  assign bus.mov_pulse  = mov_q;
  assign bus.sel_pulse  = sel_q;
  assign bus.sel_addr   = addr_q;

endmodule

// File: tb/tb_navegador_cursor.sv
// tb_navegador_cursor
//   Directed scoreboard bench for navegador_cursor with COLS=4, ROWS=3,
//   HOLD_CYC=8, REPEAT_CYC=3. Stimulus pushes the expected cycle and value
//   of every mov_pulse / sel_pulse; a monitor pops and compares whenever
//   the DUT pulses, so any missing, extra or late pulse is reported.
module tb_navegador_cursor;

  localparam logic [4:0] B_NONE   = 5'b00000;
  localparam logic [4:0] B_ARRIBA = 5'b00001;
  localparam logic [4:0] B_ABAJO  = 5'b00010;
  localparam logic [4:0] B_IZQ    = 5'b00100;
  localparam logic [4:0] B_DER    = 5'b01000;
  localparam logic [4:0] B_ELIGE  = 5'b10000;

  typedef struct {
    int cyc;
    int col;
    int row;
  } mov_exp_t;

  typedef struct {
    int cyc;
    int addr;
  } sel_exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  mov_exp_t mov_q[$];
  sel_exp_t sel_q[$];

  navegador_cursor_if #(.COLS(4), .ROWS(3)) bus ();

  navegador_cursor #(
    .COLS       (4),
    .ROWS       (3),
    .HOLD_CYC   (8),
    .REPEAT_CYC (3)
  ) dut (
    .clk_100Mhz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  // Free-running clock and cycle counter used to time expected pulses.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    mov_exp_t m;
    sel_exp_t s;
    if (bus.mov_pulse) begin
      checks++;
      if (mov_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL mov_unexpected cyc=%0d got col=%0d row=%0d, required no pulse",
                 cyc, bus.cursor_col, bus.cursor_row);
      end else begin
        m = mov_q.pop_front();
        if (cyc != m.cyc || int'(bus.cursor_col) != m.col || int'(bus.cursor_row) != m.row) begin
          failures++;
          $display("[TB] FAIL mov got cyc=%0d col=%0d row=%0d, required cyc=%0d col=%0d row=%0d",
                   cyc, bus.cursor_col, bus.cursor_row, m.cyc, m.col, m.row);
        end
      end
    end
    if (bus.sel_pulse) begin
      checks++;
      if (sel_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL sel_unexpected cyc=%0d got addr=%0d, required no pulse",
                 cyc, bus.sel_addr);
      end else begin
        s = sel_q.pop_front();
        if (cyc != s.cyc || int'(bus.sel_addr) != s.addr) begin
          failures++;
          $display("[TB] FAIL sel got cyc=%0d addr=%0d, required cyc=%0d addr=%0d",
                   cyc, bus.sel_addr, s.cyc, s.addr);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog expired at cyc=%0d, required end of stimulus", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [4:0] b, input int n);
    {bus.boton_elige, bus.boton_der, bus.boton_izq, bus.boton_abajo, bus.boton_arriba} = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic expectMove(input int at, input int col, input int row);
    mov_exp_t m;
    m.cyc = at;
    m.col = col;
    m.row = row;
    mov_q.push_back(m);
  endtask

  task automatic expectSel(input int at, input int addr);
    sel_exp_t s;
    s.cyc  = at;
    s.addr = addr;
    sel_q.push_back(s);
  endtask

  task automatic checkOutput(input string name, input int col, input int row,
                             input int mov, input int sel, input int addr);
    checks += 5;
    if (int'(bus.cursor_col) != col) begin
      failures++;
      $display("[TB] FAIL %s.col got %0d required %0d", name, bus.cursor_col, col);
    end
    if (int'(bus.cursor_row) != row) begin
      failures++;
      $display("[TB] FAIL %s.row got %0d required %0d", name, bus.cursor_row, row);
    end
    if (int'(bus.mov_pulse) != mov) begin
      failures++;
      $display("[TB] FAIL %s.mov_pulse got %0d required %0d", name, bus.mov_pulse, mov);
    end
    if (int'(bus.sel_pulse) != sel) begin
      failures++;
      $display("[TB] FAIL %s.sel_pulse got %0d required %0d", name, bus.sel_pulse, sel);
    end
    if (int'(bus.sel_addr) != addr) begin
      failures++;
      $display("[TB] FAIL %s.sel_addr got %0d required %0d", name, bus.sel_addr, addr);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int t;
    cyc      = 0;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    {bus.boton_elige, bus.boton_der, bus.boton_izq, bus.boton_abajo, bus.boton_arriba} = B_NONE;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset", 0, 0, 0, 0, 0);

    // 1: three der taps, then a fourth wraps to the next row.
    $display("[TB] der single steps");
    for (int i = 1; i <= 4; i++) begin
      t = cyc;
      if (i < 4) expectMove(t + 1, i, 0);
      else       expectMove(t + 1, 0, 1);
      applyStimulus(B_DER, 2);
      applyStimulus(B_NONE, 2);
    end

    // 2: izq/arriba/abajo wrap cases from (0,0).
    $display("[TB] wrap moves");
    doReset();
    t = cyc; expectMove(t + 1, 3, 2); applyStimulus(B_IZQ, 2);    applyStimulus(B_NONE, 2);
    t = cyc; expectMove(t + 1, 3, 1); applyStimulus(B_ARRIBA, 2); applyStimulus(B_NONE, 2);
    t = cyc; expectMove(t + 1, 3, 2); applyStimulus(B_ABAJO, 2);  applyStimulus(B_NONE, 2);
    t = cyc; expectMove(t + 1, 3, 0); applyStimulus(B_ABAJO, 2);  applyStimulus(B_NONE, 2);

    // 3: auto-repeat; release coincides with terminal count (no move).
    $display("[TB] auto-repeat");
    doReset();
    t = cyc;
    expectMove(t + 1, 1, 0);
    expectMove(t + 9, 2, 0);
    expectMove(t + 12, 3, 0);
    expectMove(t + 15, 0, 1);
    expectMove(t + 18, 1, 1);
    applyStimulus(B_DER, 20);
    applyStimulus(B_NONE, 10);
    checkOutput("after_repeat", 1, 1, 0, 0, 0);

    // 4: priority and ignored rise while another direction is held.
    $display("[TB] priority");
    t = cyc;
    expectMove(t + 1, 1, 0);
    applyStimulus(B_ARRIBA | B_DER, 2);
    applyStimulus(B_ARRIBA, 1);
    applyStimulus(B_ARRIBA | B_DER, 2);
    applyStimulus(B_NONE, 3);

    // 5: select strobe, alone and together with a move.
    $display("[TB] select");
    t = cyc; expectMove(t + 1, 2, 0); applyStimulus(B_DER, 2);   applyStimulus(B_NONE, 2);
    t = cyc; expectMove(t + 1, 2, 1); applyStimulus(B_ABAJO, 2); applyStimulus(B_NONE, 2);
    t = cyc; expectSel(t + 1, 6);     applyStimulus(B_ELIGE, 2); applyStimulus(B_NONE, 2);
    t = cyc;
    expectSel(t + 1, 6);
    expectMove(t + 1, 3, 1);
    applyStimulus(B_ELIGE | B_DER, 2);
    applyStimulus(B_NONE, 3);
    checkOutput("after_select", 3, 1, 0, 0, 6);

    // 6a: der held across reset release gives no move.
    $display("[TB] reset interactions");
    reset = 1'b1;
    applyStimulus(B_DER, 3);
    reset = 1'b0;
    applyStimulus(B_DER, 3);
    applyStimulus(B_NONE, 2);
    checkOutput("held_through_reset", 0, 0, 0, 0, 0);

    // 6b: reset in REPEAT aborts the next pending move.
    t = cyc;
    expectMove(t + 1, 1, 0);
    expectMove(t + 9, 2, 0);
    expectMove(t + 12, 3, 0);
    applyStimulus(B_DER, 13);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_repeat", 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(B_DER, 6);
    applyStimulus(B_NONE, 2);
    t = cyc;
    expectMove(t + 1, 1, 0);
    applyStimulus(B_DER, 2);
    applyStimulus(B_NONE, 4);

    checks++;
    if (mov_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL mov_pending got %0d outstanding, required 0", mov_q.size());
    end
    checks++;
    if (sel_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL sel_pending got %0d outstanding, required 0", sel_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
